// File: rtl/xor_cipher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xor_cipher_pkg
// Purpose  : Shared types and constants for the XOR cipher scheduler slice.
//            Holds the scheduler FSM state encoding, the datapath byte width
//            and the default requester count.
// Revision : 1.0 - initial release
// ============================================================================
package xor_cipher_pkg;

    localparam int XC_BYTE_W       = 8;
    localparam int XC_NREQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        XS_IDLE = 2'd0,
        XS_EXEC = 2'd1,
        XS_RESP = 2'd2
    } xs_state_t;

endpackage : xor_cipher_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. The search begins at the
//            requester after i_last_grant and wraps modulo NREQ.
// Ports    : i_req        - request vector
//            i_last_grant - index of the most recent grant
//            o_gnt        - one-hot grant (all zero when no request)
//            o_gnt_idx    - encoded grant index
//            o_any        - at least one request is pending
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_last_grant,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_gnt_idx,
    output logic            o_any
);

    int w_best_dist;
    int w_dist;

    // Each requester's distance from the search start point; the pending
    // requester with the smallest distance wins.
    always_comb begin
        w_best_dist = NREQ;
        w_dist      = 0;
        o_gnt_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + NREQ - 1 - int'(i_last_grant)) % NREQ;
            if (i_req[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                o_gnt_idx   = IDW'(i);
            end
        end
    end

    assign o_any = |i_req;

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_gnt
            assign o_gnt[g] = o_any && (o_gnt_idx == IDW'(g));
        end
    endgenerate

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/xor_cipher.sv
`default_nettype none
// ============================================================================
// Module   : xor_cipher
// Purpose  : Shared registered XOR cipher engine, one cycle of latency:
//            data_out <= data_in ^ key.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            data_in, key  - byte operands
//            data_out      - registered result (0 after reset)
// Revision : 1.0 - initial release
// ============================================================================
module xor_cipher
    import xor_cipher_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XC_BYTE_W-1:0] data_in,
    input  logic [XC_BYTE_W-1:0] key,
    output logic [XC_BYTE_W-1:0] data_out
);

    logic [XC_BYTE_W-1:0] r_out_q;
    logic [XC_BYTE_W-1:0] w_out_d;

    always_comb begin
        w_out_d = data_in ^ key;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q <= '0;
        end else begin
            r_out_q <= w_out_d;
        end
    end

    assign data_out = r_out_q;

endmodule : xor_cipher
`default_nettype wire

// File: rtl/xor_cipher_sched.sv
`default_nettype none
// ============================================================================
// Module   : xor_cipher_sched
// Purpose  : Round-robin scheduler sharing one registered XOR cipher engine
//            among NREQ byte requesters, each with its own 8-bit key.
//            One byte in flight: IDLE (accept) -> EXEC -> RESP (handshake).
// Ports    : clk, rst                   - clock, sync active-high reset
//            req_valid/req_data/req_ready - per-requester byte input
//            cfg_we/cfg_idx/cfg_key     - key register write port
//            rsp_valid/rsp_data/rsp_id/rsp_ready - result output
//            busy                       - FSM not in IDLE
// Config   : XCIPH_SCHED_KEY_ROLL_EN - when defined, a requester's key
//            increments (mod 256) on each completed response handshake.
// Revision : 1.0 - initial release
// ============================================================================
module xor_cipher_sched
    import xor_cipher_pkg::*;
#(
    parameter int NREQ = XC_NREQ_DEFAULT,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*XC_BYTE_W-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      cfg_we,
    input  logic [IDW-1:0]            cfg_idx,
    input  logic [XC_BYTE_W-1:0]      cfg_key,
    output logic                      rsp_valid,
    output logic [XC_BYTE_W-1:0]      rsp_data,
    output logic [IDW-1:0]            rsp_id,
    input  logic                      rsp_ready,
    output logic                      busy
);

    xs_state_t            r_state_q, w_state_d;
    logic [XC_BYTE_W-1:0] r_cur_data_q, w_cur_data_d;
    logic [XC_BYTE_W-1:0] r_cur_key_q, w_cur_key_d;
    logic [IDW-1:0]       r_cur_id_q, w_cur_id_d;
    logic [IDW-1:0]       r_last_grant_q, w_last_grant_d;
    logic [XC_BYTE_W-1:0] r_key_q [NREQ];
    logic [XC_BYTE_W-1:0] w_key_d [NREQ];

    logic [NREQ-1:0]      w_gnt;
    logic [IDW-1:0]       w_gnt_idx;
    logic                 w_any;
    logic [XC_BYTE_W-1:0] w_sel_data;
    logic [XC_BYTE_W-1:0] w_sel_key;
    logic [XC_BYTE_W-1:0] w_eng_out;
    logic                 w_rsp_hs;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant_q),
        .o_gnt        (w_gnt),
        .o_gnt_idx    (w_gnt_idx),
        .o_any        (w_any)
    );

    // Engine is fed from the captured byte/key, which stay stable through
    // EXEC and RESP, so its registered output holds while RESP is stalled.
    xor_cipher u_eng (
        .clk      (clk),
        .rst      (rst),
        .data_in  (r_cur_data_q),
        .key      (r_cur_key_q),
        .data_out (w_eng_out)
    );

    // Winner's byte and key; the key is the registered value, so a write
    // landing in the grant cycle is not seen by the granted byte.
    always_comb begin
        w_sel_data = '0;
        w_sel_key  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_sel_data = req_data[XC_BYTE_W*i +: XC_BYTE_W];
                w_sel_key  = r_key_q[i];
            end
        end
    end

    assign w_rsp_hs = (r_state_q == XS_RESP) && rsp_ready;

    always_comb begin
        w_state_d      = r_state_q;
        w_cur_data_d   = r_cur_data_q;
        w_cur_key_d    = r_cur_key_q;
        w_cur_id_d     = r_cur_id_q;
        w_last_grant_d = r_last_grant_q;
        req_ready      = '0;
        case (r_state_q)
            XS_IDLE: begin
                if (w_any) begin
                    req_ready      = w_gnt;
                    w_cur_data_d   = w_sel_data;
                    w_cur_key_d    = w_sel_key;
                    w_cur_id_d     = w_gnt_idx;
                    w_last_grant_d = w_gnt_idx;
                    w_state_d      = XS_EXEC;
                end
            end
            XS_EXEC: begin
                w_state_d = XS_RESP;
            end
            XS_RESP: begin
                if (rsp_ready) begin
                    w_state_d = XS_IDLE;
                end
            end
            default: begin
                w_state_d = XS_IDLE;
            end
        endcase
    end

    // Key registers: optional roll on handshake, config write has priority.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_key_d[i] = r_key_q[i];
`ifdef XCIPH_SCHED_KEY_ROLL_EN
            if (w_rsp_hs && (r_cur_id_q == IDW'(i))) begin
                w_key_d[i] = r_key_q[i] + 8'd1;
            end
`else
            if (w_rsp_hs && 1'b0) begin
                w_key_d[i] = r_key_q[i];
            end
`endif
            if (cfg_we && (cfg_idx == IDW'(i))) begin
                w_key_d[i] = cfg_key;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= XS_IDLE;
            r_cur_data_q   <= '0;
            r_cur_key_q    <= '0;
            r_cur_id_q     <= '0;
            r_last_grant_q <= IDW'(NREQ - 1);
            for (int i = 0; i < NREQ; i++) begin
                r_key_q[i] <= '0;
            end
        end else begin
            r_state_q      <= w_state_d;
            r_cur_data_q   <= w_cur_data_d;
            r_cur_key_q    <= w_cur_key_d;
            r_cur_id_q     <= w_cur_id_d;
            r_last_grant_q <= w_last_grant_d;
            for (int i = 0; i < NREQ; i++) begin
                r_key_q[i] <= w_key_d[i];
            end
        end
    end

    assign rsp_valid = (r_state_q == XS_RESP);
    assign rsp_data  = w_eng_out;
    assign rsp_id    = r_cur_id_q;
    assign busy      = (r_state_q != XS_IDLE);

endmodule : xor_cipher_sched
`default_nettype wire

// File: tb/tb_xor_cipher_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_xor_cipher_sched
// Purpose  : Self-checking bench for xor_cipher_sched (NREQ = 4): directed
//            vector table plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xor_cipher_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              cfg_we;
    logic [IDW-1:0]    cfg_idx;
    logic [7:0]        cfg_key;
    logic              rsp_valid;
    logic [7:0]        rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_ready;
    logic              busy;

    xor_cipher_sched #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_key   (cfg_key),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] key;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [6];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        cfg_we    = 1'b0;
        rsp_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input logic [7:0] k);
        cfg_we  = 1'b1;
        cfg_idx = IDW'(idx);
        cfg_key = k;
        step();
        cfg_we  = 1'b0;
    endtask

    // Single-requester transaction with bounded waits; ok=0 on timeout.
    task automatic send(input int id, input logic [7:0] d,
                        output logic [7:0] rd, output logic [IDW-1:0] rid, output bit ok);
        bit acc;
        acc = 1'b0;
        ok  = 1'b0;
        rd  = '0;
        rid = '0;
        rsp_ready        = 1'b1;
        req_valid        = '0;
        req_valid[id]    = 1'b1;
        req_data[8*id +: 8] = d;
        for (int n = 0; n < 20 && !acc; n++) begin
            #1;
            if (req_ready[id]) acc = 1'b1;
            step();
        end
        req_valid = '0;
        for (int n = 0; n < 10 && acc && !ok; n++) begin
            if (rsp_valid) begin
                rd  = rsp_data;
                rid = rsp_id;
                ok  = 1'b1;
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]     rd;
        logic [IDW-1:0] rid;
        bit             ok;
        bit             stable;
        int             grants;
        int             last_cyc;
        int             gidx;

        vecs[0] = '{id: 2, key: 8'hFF, data: 8'h0F, exp: 8'hF0};
        vecs[1] = '{id: 1, key: 8'hA5, data: 8'h5A, exp: 8'hFF};
        vecs[2] = '{id: 3, key: 8'hF0, data: 8'h0F, exp: 8'hFF};
        vecs[3] = '{id: 0, key: 8'h12, data: 8'h34, exp: 8'h26};
        vecs[4] = '{id: 2, key: 8'h81, data: 8'h18, exp: 8'h99};
        vecs[5] = '{id: 3, key: 8'hC3, data: 8'hC3, exp: 8'h00};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_key   = '0;
        rsp_ready = 1'b1;
        step();
        step();

        // Outputs while reset is held
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data",  32'(rsp_data),  32'h0);
        check("rst_rsp_id",    32'(rsp_id),    32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        rst = 1'b0;

        // Passthrough with reset keys, latency accept t -> rsp_valid t+2
        req_valid     = 4'b0001;
        req_data[7:0] = 8'h5A;
        #1;
        check("pt_accept", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        check("pt_exec_rsp_valid", 32'(rsp_valid), 32'h0);
        check("pt_exec_busy",      32'(busy),      32'h1);
        check("pt_exec_req_ready", 32'(req_ready), 32'h0);
        step();
        check("pt_rsp_valid", 32'(rsp_valid), 32'h1);
        check("pt_rsp_data",  32'(rsp_data),  32'h5A);
        check("pt_rsp_id",    32'(rsp_id),    32'h0);
        step();
        check("pt_after_hs_valid", 32'(rsp_valid), 32'h0);
        check("pt_after_hs_busy",  32'(busy),      32'h0);

        // Vector table: load key, send byte, compare result and id
        for (int i = 0; i < 6; i++) begin
            cfg_write(vecs[i].id, vecs[i].key);
            send(vecs[i].id, vecs[i].data, rd, rid, ok);
            check($sformatf("vec%0d_done", i), 32'(ok), 32'h1);
            check($sformatf("vec%0d_data", i), 32'(rd), 32'(vecs[i].exp));
            check($sformatf("vec%0d_id", i),   32'(rid), 32'(vecs[i].id));
        end

        // Round-robin: all valid, grants 0,1,2,3,0,... every 3 cycles
        do_reset();
        req_valid = 4'hF;
        req_data  = 32'h44332211;
        rsp_ready = 1'b1;
        grants    = 0;
        last_cyc  = 0;
        #1;
        for (int cyc = 0; cyc < 40 && grants < 8; cyc++) begin
            if (req_ready != '0) begin
                gidx = -1;
                for (int b = 0; b < NREQ; b++) if (req_ready[b]) gidx = b;
                check($sformatf("rr_onehot%0d", grants), 32'($countones(req_ready)), 32'h1);
                check($sformatf("rr_order%0d", grants), 32'(gidx), 32'(grants % NREQ));
                if (grants > 0) begin
                    check($sformatf("rr_spacing%0d", grants), 32'(cyc - last_cyc), 32'd3);
                end
                last_cyc = cyc;
                grants++;
            end
            step();
        end
        check("rr_grant_count", 32'(grants), 32'd8);
        req_valid = '0;
        do_reset();

        // Backpressure: hold RESP for 5 cycles with another requester waiting
        req_valid       = 4'b0010;
        req_data[15:8]  = 8'h3C;
        rsp_ready       = 1'b0;
        #1;
        check("bp_accept", 32'(req_ready), 32'h2);
        step();
        req_valid       = 4'b0100;
        req_data[23:16] = 8'h77;
        step();
        stable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (!(rsp_valid === 1'b1 && rsp_data === 8'h3C && rsp_id === 2'd1 && req_ready === 4'b0000))
                stable = 1'b0;
            step();
        end
        check("bp_hold_stable", 32'(stable), 32'h1);
        rsp_ready = 1'b1;
        #1;
        check("bp_release_valid", 32'(rsp_valid), 32'h1);
        step();
        check("bp_next_idle_valid", 32'(rsp_valid), 32'h0);
        check("bp_next_grant",      32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        step();
        check("bp_second_valid", 32'(rsp_valid), 32'h1);
        check("bp_second_id",    32'(rsp_id),    32'h2);
        check("bp_second_data",  32'(rsp_data),  32'h77);
        step();

        // Key write during EXEC does not affect the in-flight byte
        cfg_write(1, 8'h22);
        req_valid      = 4'b0010;
        req_data[15:8] = 8'h00;
        #1;
        check("mf_accept", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        cfg_we    = 1'b1;
        cfg_idx   = 2'd1;
        cfg_key   = 8'h11;
        step();
        cfg_we = 1'b0;
        check("mf_old_key_data", 32'(rsp_data), 32'h22);
        check("mf_old_key_id",   32'(rsp_id),   32'h1);
        step();
        send(1, 8'h00, rd, rid, ok);
        check("mf_new_done", 32'(ok), 32'h1);
`ifdef XCIPH_SCHED_KEY_ROLL_EN
        check("mf_new_key_data", 32'(rd), 32'h12);
`else
        check("mf_new_key_data", 32'(rd), 32'h11);
`endif

        // Key write in the grant cycle: captured byte uses the old key
        cfg_write(0, 8'h40);
        req_valid     = 4'b0001;
        req_data[7:0] = 8'h01;
        cfg_we        = 1'b1;
        cfg_idx       = 2'd0;
        cfg_key       = 8'h80;
        #1;
        check("sc_accept", 32'(req_ready), 32'h1);
        step();
        cfg_we    = 1'b0;
        req_valid = '0;
        step();
        check("sc_old_key_data", 32'(rsp_data), 32'h41);
        step();
        send(0, 8'h01, rd, rid, ok);
        check("sc_new_done", 32'(ok), 32'h1);
`ifdef XCIPH_SCHED_KEY_ROLL_EN
        check("sc_new_key_data", 32'(rd), 32'h80);
`else
        check("sc_new_key_data", 32'(rd), 32'h81);
`endif

        // Reset asserted while in RESP
        cfg_write(3, 8'h0F);
        req_valid       = 4'b1000;
        req_data[31:24] = 8'hAA;
        rsp_ready       = 1'b0;
        step();
        req_valid = '0;
        step();
        check("rr_resp_valid_before_rst", 32'(rsp_valid), 32'h1);
        rst = 1'b1;
        step();
        check("rstresp_valid", 32'(rsp_valid), 32'h0);
        check("rstresp_busy",  32'(busy),      32'h0);
        check("rstresp_data",  32'(rsp_data),  32'h0);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        step();
        check("rstresp_idle_busy", 32'(busy), 32'h0);
        // Keys were cleared by the reset: passthrough again on requester 3
        send(3, 8'hAA, rd, rid, ok);
        check("rstresp_key_cleared", 32'(rd), 32'hAA);

`ifdef XCIPH_SCHED_KEY_ROLL_EN
        // Key roll: 0xFF then wraps to 0x00
        cfg_write(0, 8'hFF);
        send(0, 8'h00, rd, rid, ok);
        check("roll_first", 32'(rd), 32'hFF);
        send(0, 8'h00, rd, rid, ok);
        check("roll_wrap", 32'(rd), 32'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_xor_cipher_sched
`default_nettype wire
